// File: rtl/input_io_controller.sv
// input_io_controller
// Blocks the CPU on an input instruction until the enter pushbutton has been
// debounced, then captures the switch bank into in_data with a one-cycle
// in_valid strobe. A press must be debounced as released before another
// capture can happen, so one press never satisfies two input instructions.
//
// Optional feature: define INPUT_SIGN_EXTEND_EN to sign-extend the captured
// switches into in_data. Without it the capture is zero-extended.
module input_io_controller #(
    parameter int SW_WIDTH        = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ENTER_ACTIVE    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_req,
    input  logic                  enter,
    input  logic [SW_WIDTH-1:0]   switches,
    output logic                  stall,
    output logic                  in_valid,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic [7:0]            in_count
);

    // Pin level that means "pressed", and the level the synchronizer
    // starts from so reset never looks like a press.
    localparam logic ACTIVE_LVL   = (ENTER_ACTIVE != 0);
    localparam logic INACTIVE_LVL = ~ACTIVE_LVL;
    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        DEBOUNCE,
        DONE,
        WAIT_RELEASE
    } state_t;

    logic                  enter_meta_reg;
    logic                  enter_s_reg;
    logic [SW_WIDTH-1:0]   sw_meta_reg;
    logic [SW_WIDTH-1:0]   sw_s_reg;

    state_t                state_reg;
    logic [7:0]            cnt_reg;
    logic                  in_valid_reg;
    logic [DATA_WIDTH-1:0] in_data_reg;
    logic [7:0]            in_count_reg;

    logic                  enter_active;
    logic [7:0]            cnt_inc;
    logic                  ext_bit;
    logic [DATA_WIDTH-1:0] capture_word;

    assign enter_active = (enter_s_reg == ACTIVE_LVL);
    assign cnt_inc      = cnt_reg + 8'd1;

`ifdef INPUT_SIGN_EXTEND_EN
    assign ext_bit = sw_s_reg[SW_WIDTH-1];
`else
    assign ext_bit = 1'b0;
`endif

    // Build the capture word bit by bit: switch bits first, then the
    // extension bit for every position above the switch bank.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_capture
            if (gi < SW_WIDTH) begin : g_sw
                assign capture_word[gi] = sw_s_reg[gi];
            end else begin : g_ext
                assign capture_word[gi] = ext_bit;
            end
        end
    endgenerate

    // Two-flop synchronizer for the asynchronous pushbutton and switches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enter_meta_reg <= INACTIVE_LVL;
            enter_s_reg    <= INACTIVE_LVL;
            sw_meta_reg    <= '0;
            sw_s_reg       <= '0;
        end else begin
            enter_meta_reg <= enter;
            enter_s_reg    <= enter_meta_reg;
            sw_meta_reg    <= switches;
            sw_s_reg       <= sw_meta_reg;
        end
    end

    // Press/release handshake FSM with registered strobe, data and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            in_valid_reg <= 1'b0;
            in_data_reg  <= '0;
            in_count_reg <= 8'd0;
        end else begin
            in_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= 8'd0;
                    if (in_req) begin
                        state_reg <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (!in_req) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 8'd0;
                    end else if (enter_active) begin
                        state_reg <= DEBOUNCE;
                        cnt_reg   <= 8'd1;
                    end
                end
                DEBOUNCE: begin
                    // A flush wins over a capture that would happen this edge.
                    if (!in_req) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 8'd0;
                    end else if (!enter_active) begin
                        state_reg <= WAIT_PRESS;
                        cnt_reg   <= 8'd0;
                    end else if (cnt_reg >= DEB_LIMIT) begin
                        state_reg    <= DONE;
                        cnt_reg      <= 8'd0;
                        in_valid_reg <= 1'b1;
                        in_data_reg  <= capture_word;
                        in_count_reg <= in_count_reg + 8'd1;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                DONE: begin
                    state_reg <= WAIT_RELEASE;
                    cnt_reg   <= 8'd0;
                end
                WAIT_RELEASE: begin
                    // Count consecutive released samples; any bounce restarts.
                    if (enter_active) begin
                        cnt_reg <= 8'd0;
                    end else if (cnt_inc >= DEB_LIMIT) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 8'd0;
                end
            endcase
        end
    end

    assign stall    = in_req && (state_reg != DONE);
    assign in_valid = in_valid_reg;
    assign in_data  = in_data_reg;
    assign in_count = in_count_reg;

endmodule

// File: tb/tb_input_io_controller.sv
// Directed testbench for input_io_controller (default parameters, enter
// active-low). Each task drives one scenario and checks outputs 1 time unit
// after the clock edge.
module tb_input_io_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_req;
    logic        enter;
    logic [15:0] switches;
    logic        stall;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_io_controller #(
        .SW_WIDTH(16),
        .DATA_WIDTH(32),
        .DEBOUNCE_CYCLES(4),
        .ENTER_ACTIVE(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_req(in_req),
        .enter(enter),
        .switches(switches),
        .stall(stall),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_count(in_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_req = 1'b1; enter = 1'b1; switches = 16'hFFFF;
        repeat (3) tick();
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_req1: got %b want 1", stall); end
        in_req = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_req0: got %b want 0", stall); end
        checks++;
        if (in_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", in_valid); end
        checks++;
        if (in_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", in_data); end
        checks++;
        if (in_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", in_count); end
        $display("reset: stall=%b valid=%b data=%h count=%0d", stall, in_valid, in_data, in_count);
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    // Edge 1 is the first edge that samples the pin pressed; strobe at edge 7.
    task automatic test_press_latency;
        logic exp_v;
        in_req = 1'b1; switches = 16'h00A5;
        tick(); tick();
        enter = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_v = (k == 7);
            checks++;
            if (in_valid !== exp_v) begin errors++; $display("FAIL latency_valid edge %0d: got %b want %b", k, in_valid, exp_v); end
            checks++;
            if (stall !== !exp_v) begin errors++; $display("FAIL latency_stall edge %0d: got %b want %b", k, stall, !exp_v); end
        end
        checks++;
        if (in_data !== 32'h000000A5) begin errors++; $display("FAIL latency_data: got %h want 000000a5", in_data); end
        checks++;
        if (in_count !== 8'd1) begin errors++; $display("FAIL latency_count: got %0d want 1", in_count); end
        $display("press: data=%h count=%0d", in_data, in_count);
        in_req = 1'b0;
        tick();
        checks++;
        if (in_valid !== 1'b0) begin errors++; $display("FAIL latency_pulse_width: got %b want 0", in_valid); end
        enter = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_glitch;
        logic exp_v;
        in_req = 1'b1; switches = 16'h0033;
        tick(); tick();
        enter = 1'b0;
        tick(); tick();
        enter = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (in_valid !== 1'b0 || stall !== 1'b1) begin
                errors++; $display("FAIL glitch cycle %0d: valid=%b stall=%b want 0/1", k, in_valid, stall);
            end
        end
        checks++;
        if (in_count !== 8'd1) begin errors++; $display("FAIL glitch_count: got %0d want 1", in_count); end
        // Still waiting for a press: a clean press must now be accepted.
        enter = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_v = (k == 7);
            checks++;
            if (in_valid !== exp_v) begin errors++; $display("FAIL glitch_repress edge %0d: got %b want %b", k, in_valid, exp_v); end
        end
        checks++;
        if (in_data !== 32'h00000033 || in_count !== 8'd2) begin
            errors++; $display("FAIL glitch_repress_capture: data=%h count=%0d want 00000033/2", in_data, in_count);
        end
        $display("glitch: data=%h count=%0d", in_data, in_count);
    endtask

    // Continues with enter still held from the previous capture.
    task automatic test_back_to_back;
        logic exp_v;
        in_req = 1'b0;
        tick();
        in_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (stall !== 1'b1 || in_valid !== 1'b0) begin
                errors++; $display("FAIL held_second_req cycle %0d: stall=%b valid=%b want 1/0", k, stall, in_valid);
            end
        end
        switches = 16'h0044;
        enter = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (stall !== 1'b1 || in_valid !== 1'b0) begin
                errors++; $display("FAIL release_wait cycle %0d: stall=%b valid=%b want 1/0", k, stall, in_valid);
            end
        end
        enter = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_v = (k == 7);
            checks++;
            if (in_valid !== exp_v) begin errors++; $display("FAIL second_press edge %0d: got %b want %b", k, in_valid, exp_v); end
        end
        checks++;
        if (in_data !== 32'h00000044 || in_count !== 8'd3) begin
            errors++; $display("FAIL second_press_capture: data=%h count=%0d want 00000044/3", in_data, in_count);
        end
        $display("back_to_back: data=%h count=%0d", in_data, in_count);
        in_req = 1'b0;
        tick();
        enter = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_flush;
        in_req = 1'b1; switches = 16'h1234;
        tick(); tick();
        enter = 1'b0;
        repeat (4) tick();
        in_req = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 5) switches = 16'h5555;
            checks++;
            if (in_valid !== 1'b0) begin errors++; $display("FAIL flush_valid cycle %0d: got %b want 0", k, in_valid); end
        end
        checks++;
        if (in_count !== 8'd3) begin errors++; $display("FAIL flush_count: got %0d want 3", in_count); end
        checks++;
        if (in_data !== 32'h00000044) begin errors++; $display("FAIL flush_data_hold: got %h want 00000044", in_data); end
        $display("flush: data=%h count=%0d", in_data, in_count);
    endtask

    // Enter is still held from the flush when in_req rises in IDLE.
    task automatic test_held_enter_sign;
        logic        exp_v;
        logic [31:0] exp_data;
`ifdef INPUT_SIGN_EXTEND_EN
        exp_data = 32'hFFFF8001;
`else
        exp_data = 32'h00008001;
`endif
        switches = 16'h8001;
        tick(); tick();
        in_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v = (k == 6);
            checks++;
            if (in_valid !== exp_v) begin errors++; $display("FAIL held_press edge %0d: got %b want %b", k, in_valid, exp_v); end
        end
        checks++;
        if (in_data !== exp_data) begin errors++; $display("FAIL sign_ext_data: got %h want %h", in_data, exp_data); end
        checks++;
        if (in_count !== 8'd4) begin errors++; $display("FAIL held_press_count: got %0d want 4", in_count); end
        $display("held_press: data=%h count=%0d", in_data, in_count);
        in_req = 1'b0;
        tick();
        enter = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_count_wrap;
        bit seen;
        for (int i = 0; i < 252; i++) begin
            in_req = 1'b1; switches = 16'(i); enter = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                tick();
                if (in_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen) begin errors++; $display("FAIL wrap_capture %0d: no in_valid within 20 cycles", i); end
            if (i == 250) begin
                checks++;
                if (in_count !== 8'd255) begin errors++; $display("FAIL wrap_count_255: got %0d want 255", in_count); end
            end
            in_req = 1'b0; enter = 1'b1;
            repeat (10) tick();
        end
        checks++;
        if (in_count !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d want 0", in_count); end
        checks++;
        if (in_data !== 32'h000000FB) begin errors++; $display("FAIL wrap_data: got %h want 000000fb", in_data); end
        $display("wrap: data=%h count=%0d", in_data, in_count);
    endtask

    task automatic test_reset_mid;
        logic exp_v;
        in_req = 1'b1; switches = 16'h5A5A; enter = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (in_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", in_valid); end
        checks++;
        if (in_data !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h want 00000000", in_data); end
        checks++;
        if (in_count !== 8'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", in_count); end
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL midreset_stall: got %b want 1", stall); end
        rst_n = 1'b1; in_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (in_valid !== 1'b0) begin errors++; $display("FAIL postreset_valid cycle %0d: got %b want 0", k, in_valid); end
        end
        // Fresh request from IDLE with enter held: capture after six edges.
        in_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v = (k == 6);
            checks++;
            if (in_valid !== exp_v) begin errors++; $display("FAIL postreset_press edge %0d: got %b want %b", k, in_valid, exp_v); end
        end
        checks++;
        if (in_data !== 32'h00005A5A || in_count !== 8'd1) begin
            errors++; $display("FAIL postreset_capture: data=%h count=%0d want 00005a5a/1", in_data, in_count);
        end
        $display("reset_mid: data=%h count=%0d", in_data, in_count);
        in_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_back_to_back();
        test_flush();
        test_held_enter_sign();
        test_count_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
